mips_cpu_data_bridge: RTL and testbench
=======================================

# mips_cpu_data_bridge

Downstream adapter between the Harvard CPU data port and an Avalon-MM style data bus with `waitrequest`. It registers each CPU load or store, issues it on the bus, and holds the request until the bus accepts it. It returns load data to the CPU and stalls the CPU core by driving its `clk_enable` low while a transaction is outstanding. Cycles without a memory access pass through with no stall.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum number of `waitrequest`-high cycles before a transaction is abandoned; 0 disables the timeout.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `ext_clk_enable`  in  1  system run enable; when low, no new transaction is started and the CPU stays stalled
- `cpu_data_read`  in  1  CPU load request
- `cpu_data_write`  in  1  CPU store request
- `cpu_data_address`  in  32  CPU byte address, already word-aligned
- `cpu_data_byteenable`  in  4  CPU byte lanes
- `cpu_data_writedata`  in  32  CPU store data
- `cpu_data_readdata`  out  32  load data returned to the CPU
- `cpu_clk_enable`  out  1  clock enable to the CPU core
- `avm_address`  out  32  bus address
- `avm_read`  out  1  bus read strobe
- `avm_write`  out  1  bus write strobe
- `avm_byteenable`  out  4  bus byte lanes
- `avm_writedata`  out  32  bus write data
- `avm_readdata`  in  32  bus read data, valid in the cycle `waitrequest` is low
- `avm_waitrequest`  in  1  bus stall
- `bus_error`  out  1  sticky flag, set on timeout

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - `cpu_clk_enable = ext_clk_enable & ~(cpu_data_read | cpu_data_write)`.
  - If `ext_clk_enable` is high and a request is present, latch address (bits [1:0] forced to 0), byteenable, writedata and direction into internal registers, then go to BUS.
  - If read and write are both asserted, the write takes priority and the read is dropped.
- **BUS**
  - `avm_read`/`avm_write` are driven from the latched direction; `avm_address`, `avm_byteenable` and `avm_writedata` come from the latched registers.
  - `cpu_clk_enable = 0`.
  - When `avm_waitrequest == 0`: the transaction is accepted. A read latches `avm_readdata` into `rdata_reg`. Go to DONE.
  - Otherwise the wait counter increments.
- **DONE**
  - `cpu_clk_enable = ext_clk_enable`; `cpu_data_readdata = rdata_reg`.
  - Once `ext_clk_enable` is high, return to IDLE. If it is low, stay in DONE; the request is not reissued.
- **Outside BUS:** `avm_read = avm_write = 0`. The other `avm_*` outputs hold their last latched values.
- **`cpu_data_readdata` in IDLE** shows the last `rdata_reg`. The CPU ignores it there.
- **Timeout** (`TIMEOUT_CYCLES > 0`):
  - When the wait counter reaches `TIMEOUT_CYCLES` while `waitrequest` is still high, drop the strobe, set `rdata_reg = 0`, set `bus_error`, and go to DONE.
  - `bus_error` clears only on reset.
  - The counter is at least 16 bits wide; saturating arithmetic is used and it clears on entry to BUS.
- `ext_clk_enable` low during BUS does not abort the transaction; the bridge completes it and then waits in DONE.

## Timing
- Reset values: state IDLE; `avm_read`, `avm_write` = 0; `avm_address`, `avm_writedata`, `cpu_data_readdata`, `rdata_reg` = 0; `avm_byteenable` = 0; `bus_error` = 0; counter = 0.
- `cpu_clk_enable` is combinational from state and inputs. During reset it follows IDLE rules.
- Memory access with zero wait states takes 3 cycles:
  - cycle 0: IDLE, stall
  - cycle 1: BUS, strobe accepted
  - cycle 2: DONE, CPU commits
- Each `waitrequest`-high cycle adds one cycle.
- A non-memory instruction costs 1 cycle.
- Back-to-back memory instructions: after DONE, the next request is detected in IDLE on the following cycle, so there are no gaps beyond the 3-cycle minimum.
- The strobe is asserted for exactly the BUS cycles; one bus transaction per CPU instruction.
- Reset mid-transaction: in the next cycle, state is IDLE and the strobe is deasserted. An in-flight bus transaction is abandoned.

## Test plan
- **Load, zero wait:** CPU read at 0x00001004; `waitrequest = 0`; `avm_readdata = 0xCAFEF00D`. Expect:
  - `avm_read` high for 1 cycle with address 0x00001004
  - `cpu_clk_enable` pattern 0, 0, 1
  - `cpu_data_readdata = 0xCAFEF00D` in the DONE cycle
- **Store with 3 wait states:** write 0x12345678, byteenable 4'b0011. Expect:
  - `avm_write` high for 4 cycles with stable data and byteenable
  - `cpu_clk_enable` low for 5 cycles, then high for 1
- **Non-memory cycles:** no request, `ext_clk_enable = 1`. Expect `cpu_clk_enable = 1` every cycle and no strobes.
- **Timeout:** `TIMEOUT_CYCLES = 8`, `waitrequest` held high on a read. Expect:
  - strobe dropped after 8 wait cycles
  - `bus_error = 1`, `cpu_data_readdata = 0`
  - CPU released in the DONE cycle
- **`ext_clk_enable` low during BUS:** expect the transaction to complete, the bridge to hold in DONE with `cpu_clk_enable = 0`, no second strobe, and release on the cycle `ext_clk_enable` returns high.
- **Reset mid-BUS:** expect `avm_read = 0`, state IDLE and `bus_error = 0` on the next cycle; the following request behaves as a fresh 3-cycle access.

Source files
------------

// File: rtl/mips_cpu_data_bridge_if.sv
//------------------------------------------------------------------------------
// Module   : mips_cpu_data_bridge_if
// Purpose  : Avalon-MM style data bus with waitrequest, bridge side = master.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface mips_cpu_data_bridge_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/mips_cpu_data_bridge.sv
//------------------------------------------------------------------------------
// Module   : mips_cpu_data_bridge
// Purpose  : Registers CPU loads/stores, issues them on the data bus and stalls
//            the CPU clock enable until the bus has accepted the request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mips_cpu_data_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ext_clk_enable,
  input  logic                          cpu_data_read,
  input  logic                          cpu_data_write,
  input  logic [31:0]                   cpu_data_address,
  input  logic [3:0]                    cpu_data_byteenable,
  input  logic [31:0]                   cpu_data_writedata,
  output logic [31:0]                   cpu_data_readdata,
  output logic                          cpu_clk_enable,
  mips_cpu_data_bridge_if.master        avm,
  output logic                          bus_error
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        rdata_reg;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;
  logic               cpu_req;

  assign cpu_req           = cpu_data_read | cpu_data_write;
  assign cpu_data_readdata = rdata_reg;

  // The counter reaches the limit during the wait cycle it is about to count.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
      assign timeout_hit = (wait_cnt >= LIMIT);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Reset forces the IDLE stall rule even while the state register still holds BUS.
  always_comb begin
    cpu_clk_enable = 1'b0;
    if (reset || state == IDLE)
      cpu_clk_enable = ext_clk_enable & ~cpu_req;
    else if (state == DONE)
      cpu_clk_enable = ext_clk_enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm.read       <= 1'b0;
      avm.write      <= 1'b0;
      avm.address    <= 32'd0;
      avm.byteenable <= 4'd0;
      avm.writedata  <= 32'd0;
      rdata_reg      <= 32'd0;
      bus_error      <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_clk_enable && cpu_req) begin
            avm.address    <= cpu_data_address & 32'hFFFF_FFFC;
            avm.byteenable <= cpu_data_byteenable;
            avm.writedata  <= cpu_data_writedata;
            avm.write      <= cpu_data_write;
            avm.read       <= ~cpu_data_write;
            wait_cnt       <= '0;
            state          <= BUS;
          end
        end
        BUS: begin
          if (!avm.waitrequest) begin
            if (avm.read)
              rdata_reg <= avm.readdata;
            avm.read  <= 1'b0;
            avm.write <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            avm.read  <= 1'b0;
            avm.write <= 1'b0;
            rdata_reg <= 32'd0;
            bus_error <= 1'b1;
            state     <= DONE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          if (ext_clk_enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_data_bridge.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_cpu_data_bridge
// Purpose  : Self-checking bench for mips_cpu_data_bridge with a bus scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mips_cpu_data_bridge;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_clk_enable;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_address;
  logic [3:0]  cpu_data_byteenable;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        bus_error;

  mips_cpu_data_bridge_if avm_if ();

  mips_cpu_data_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ext_clk_enable      (ext_clk_enable),
    .cpu_data_read       (cpu_data_read),
    .cpu_data_write      (cpu_data_write),
    .cpu_data_address    (cpu_data_address),
    .cpu_data_byteenable (cpu_data_byteenable),
    .cpu_data_writedata  (cpu_data_writedata),
    .cpu_data_readdata   (cpu_data_readdata),
    .cpu_clk_enable      (cpu_clk_enable),
    .avm                 (avm_if),
    .bus_error           (bus_error)
  );

  always #5 clk = ~clk;

  wire strobe = avm_if.read | avm_if.write;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  txn_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every accepted bus beat must match the oldest outstanding CPU request.
  always @(negedge clk) begin : sb_monitor
    txn_t e;
    if (!reset && strobe) begin
      check("strobe_excl", 32'(avm_if.read & avm_if.write), 32'd0);
      if (!avm_if.waitrequest) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_dir",  32'(avm_if.write), 32'(e.wr));
          check("sb_addr", avm_if.address, e.addr);
          check("sb_be",   32'(avm_if.byteenable), 32'(e.be));
          if (e.wr)
            check("sb_wdata", avm_if.writedata, e.data);
        end
      end
    end
  end

  task automatic push_txn(input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    txn_t e;
    e.wr   = wr;
    e.addr = addr & 32'hFFFF_FFFC;
    e.be   = be;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic mem_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input int nwait,
                            input logic [31:0] rdata);
    int stalls;
    int strobes;
    bit done;
    stalls  = 0;
    strobes = 0;
    done    = 1'b0;
    push_txn(wr, addr, be, wdata);
    cpu_data_read       = rd;
    cpu_data_write      = wr;
    cpu_data_address    = addr;
    cpu_data_byteenable = be;
    cpu_data_writedata  = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      avm_if.waitrequest = (strobes < nwait);
      avm_if.readdata    = (strobes < nwait) ? 32'hDEAD_BEEF : rdata;
      @(negedge clk);
      if (strobe) begin
        strobes++;
        check({tag, "_addr"}, avm_if.address, addr & 32'hFFFF_FFFC);
        check({tag, "_be"}, 32'(avm_if.byteenable), 32'(be));
        if (wr)
          check({tag, "_wdata"}, avm_if.writedata, wdata);
      end
      if (cpu_clk_enable) begin
        done = 1'b1;
        if (!wr)
          check({tag, "_rdata"}, cpu_data_readdata, rdata);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    cpu_data_read      = 1'b0;
    cpu_data_write     = 1'b0;
    avm_if.waitrequest = 1'b0;
    check({tag, "_done"},    32'(done),    32'd1);
    check({tag, "_stalls"},  32'(stalls),  32'(2 + nwait));
    check({tag, "_strobes"}, 32'(strobes), 32'(1 + nwait));
  endtask

  int stalls_m;
  int strobes_m;
  bit done_m;

  initial begin
    reset               = 1'b1;
    ext_clk_enable      = 1'b1;
    cpu_data_read       = 1'b0;
    cpu_data_write      = 1'b0;
    cpu_data_address    = 32'd0;
    cpu_data_byteenable = 4'd0;
    cpu_data_writedata  = 32'd0;
    avm_if.readdata     = 32'd0;
    avm_if.waitrequest  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_read",  32'(avm_if.read), 32'd0);
    check("rst_write", 32'(avm_if.write), 32'd0);
    check("rst_addr",  avm_if.address, 32'd0);
    check("rst_be",    32'(avm_if.byteenable), 32'd0);
    check("rst_wdata", avm_if.writedata, 32'd0);
    check("rst_rdata", cpu_data_readdata, 32'd0);
    check("rst_err",   32'(bus_error), 32'd0);
    check("rst_cce",   32'(cpu_clk_enable), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    mem_access("ld0", 1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 0, 32'hCAFE_F00D);
    mem_access("st3", 1'b0, 1'b1, 32'h0000_2000, 4'b0011, 32'h1234_5678, 3, 32'h0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nomem_cce",    32'(cpu_clk_enable), 32'd1);
      check("nomem_strobe", 32'(strobe), 32'd0);
      @(posedge clk); #1;
    end

    mem_access("ld_unal", 1'b1, 1'b0, 32'h0000_3006, 4'h3, 32'h0, 2, 32'h5555_AAAA);
    mem_access("rw_prio", 1'b1, 1'b1, 32'h0000_0040, 4'hC, 32'hA5A5_5A5A, 1, 32'h0);
    mem_access("ld_b2b",  1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 0, 32'h0F0F_1234);

    // ext_clk_enable dropped while the read is on the bus
    push_txn(1'b0, 32'h0000_6000, 4'hF, 32'h0);
    cpu_data_read       = 1'b1;
    cpu_data_address    = 32'h0000_6000;
    cpu_data_byteenable = 4'hF;
    avm_if.waitrequest  = 1'b1;
    avm_if.readdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ek_idle_cce", 32'(cpu_clk_enable), 32'd0);
    @(posedge clk); #1;
    ext_clk_enable = 1'b0;
    @(negedge clk);
    check("ek_bus_strobe", 32'(avm_if.read), 32'd1);
    check("ek_bus_cce", 32'(cpu_clk_enable), 32'd0);
    @(posedge clk); #1;
    avm_if.waitrequest = 1'b0;
    avm_if.readdata    = 32'h0BAD_CAFE;
    @(negedge clk);
    check("ek_accept_strobe", 32'(avm_if.read), 32'd1);
    @(posedge clk); #1;
    avm_if.readdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ek_hold_cce",    32'(cpu_clk_enable), 32'd0);
      check("ek_hold_strobe", 32'(strobe), 32'd0);
      check("ek_hold_rdata",  cpu_data_readdata, 32'h0BAD_CAFE);
      @(posedge clk); #1;
    end
    ext_clk_enable = 1'b1;
    @(negedge clk);
    check("ek_release_cce", 32'(cpu_clk_enable), 32'd1);
    @(posedge clk); #1;
    cpu_data_read = 1'b0;
    @(negedge clk);
    check("ek_after_cce",    32'(cpu_clk_enable), 32'd1);
    check("ek_after_strobe", 32'(strobe), 32'd0);
    @(posedge clk); #1;

    // Read that never gets accepted
    check("to_err_pre", 32'(bus_error), 32'd0);
    cpu_data_read       = 1'b1;
    cpu_data_address    = 32'h0000_5000;
    cpu_data_byteenable = 4'hF;
    avm_if.waitrequest  = 1'b1;
    avm_if.readdata     = 32'h1111_2222;
    stalls_m  = 0;
    strobes_m = 0;
    done_m    = 1'b0;
    for (int c = 0; c < 40 && !done_m; c++) begin
      @(negedge clk);
      if (strobe) strobes_m++;
      if (cpu_clk_enable) begin
        done_m = 1'b1;
        check("to_rdata",  cpu_data_readdata, 32'd0);
        check("to_err",    32'(bus_error), 32'd1);
        check("to_strobe_done", 32'(strobe), 32'd0);
      end else begin
        stalls_m++;
      end
      @(posedge clk); #1;
    end
    cpu_data_read      = 1'b0;
    avm_if.waitrequest = 1'b0;
    check("to_done",    32'(done_m), 32'd1);
    check("to_strobes", 32'(strobes_m), 32'(TIMEOUT));
    check("to_stalls",  32'(stalls_m), 32'(TIMEOUT + 1));
    @(negedge clk);
    check("to_err_sticky", 32'(bus_error), 32'd1);
    @(posedge clk); #1;

    // Reset while a read is stuck on the bus
    cpu_data_read      = 1'b1;
    cpu_data_address   = 32'h0000_7000;
    avm_if.waitrequest = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rm_strobe", 32'(avm_if.read), 32'd1);
    reset         = 1'b1;
    cpu_data_read = 1'b0;
    #1;
    check("rm_cce_in_reset", 32'(cpu_clk_enable), 32'd1);
    @(posedge clk); #1;
    reset              = 1'b0;
    avm_if.waitrequest = 1'b0;
    @(negedge clk);
    check("rm_read", 32'(avm_if.read), 32'd0);
    check("rm_err",  32'(bus_error), 32'd0);
    check("rm_cce",  32'(cpu_clk_enable), 32'd1);
    @(posedge clk); #1;
    mem_access("rm_fresh", 1'b1, 1'b0, 32'h0000_7008, 4'hF, 32'h0, 0, 32'h7777_0001);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
